// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_decoder_if
//  Purpose  : UART byte stream in, register / waveform-RAM write ports out.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if #(
    parameter int WAVE_ADDR_W = 10
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   reg_wr_en;
    logic [7:0]             reg_addr;
    logic [15:0]            reg_wdata;
    logic                   wave_wr_en;
    logic [WAVE_ADDR_W-1:0] wave_addr;
    logic [15:0]            wave_wdata;
    logic                   frame_ok;
    logic                   frame_err;
    logic [1:0]             err_code;
    logic                   busy;

    modport master (
        output rx_data, rx_valid,
        input  reg_wr_en, reg_addr, reg_wdata, wave_wr_en, wave_addr, wave_wdata,
        input  frame_ok, frame_err, err_code, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output reg_wr_en, reg_addr, reg_wdata, wave_wr_en, wave_addr, wave_wdata,
        output frame_ok, frame_err, err_code, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_decoder
//  Purpose  : Deframes A5|CMD|AH|AL|LEN|PAYLOAD|CHK host packets into writes.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder #(
    parameter int          WAVE_ADDR_W    = 10,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_cmd_decoder_if.slave    bus
);
    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam logic [7:0]  CMD_REG    = 8'h01;
    localparam logic [7:0]  CMD_WAVE   = 8'h02;
    localparam logic [31:0] TIMER_LAST = TIMEOUT_CYCLES - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_LEN, S_D_HI, S_D_LO, S_CHK
    } state_t;

    state_t                 state_q;
    logic                   is_wave_q;
    logic [15:0]            addr_q;
    logic [7:0]             len_q;
    logic [7:0]             idx_q;
    logic [7:0]             data_hi_q;
    logic [15:0]            reg_data_q;
    logic [7:0]             chk_q;
    logic [31:0]            timer_q;

    logic                   reg_wr_en_q;
    logic [7:0]             reg_addr_q;
    logic [15:0]            reg_wdata_q;
    logic                   wave_wr_en_q;
    logic [WAVE_ADDR_W-1:0] wave_addr_q;
    logic [15:0]            wave_wdata_q;
    logic                   frame_ok_q;
    logic                   frame_err_q;
    logic [1:0]             err_code_q;

    logic [7:0]             rx_byte;
    logic [WAVE_ADDR_W-1:0] wave_addr_d;

    assign rx_byte     = bus.rx_data;
    // Address arithmetic is done at RAM width so it wraps at the top of memory.
    assign wave_addr_d = addr_q[WAVE_ADDR_W-1:0] + WAVE_ADDR_W'(idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            is_wave_q    <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            data_hi_q    <= '0;
            reg_data_q   <= '0;
            chk_q        <= '0;
            timer_q      <= '0;
            reg_wr_en_q  <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            wave_wr_en_q <= 1'b0;
            wave_addr_q  <= '0;
            wave_wdata_q <= '0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            reg_wr_en_q  <= 1'b0;
            wave_wr_en_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;

            if (bus.rx_valid) begin
                // An arriving byte always beats a timer expiring in the same cycle.
                timer_q <= '0;
                unique case (state_q)
                    S_IDLE: begin
                        if (rx_byte == SYNC_BYTE) state_q <= S_CMD;
                    end
                    S_CMD: begin
                        if (rx_byte == CMD_REG || rx_byte == CMD_WAVE) begin
                            is_wave_q <= (rx_byte == CMD_WAVE);
                            chk_q     <= rx_byte;
                            state_q   <= S_ADDR_HI;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd1;
                            state_q     <= S_IDLE;
                        end
                    end
                    S_ADDR_HI: begin
                        addr_q[15:8] <= rx_byte;
                        chk_q        <= chk_q ^ rx_byte;
                        state_q      <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        addr_q[7:0] <= rx_byte;
                        chk_q       <= chk_q ^ rx_byte;
                        state_q     <= S_LEN;
                    end
                    S_LEN: begin
                        chk_q <= chk_q ^ rx_byte;
                        len_q <= rx_byte;
                        idx_q <= '0;
                        if (is_wave_q ? (rx_byte == 8'd0) : (rx_byte != 8'd2)) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd2;
                            state_q     <= S_IDLE;
                        end else begin
                            state_q <= S_D_HI;
                        end
                    end
                    S_D_HI: begin
                        data_hi_q <= rx_byte;
                        chk_q     <= chk_q ^ rx_byte;
                        state_q   <= S_D_LO;
                    end
                    S_D_LO: begin
                        chk_q <= chk_q ^ rx_byte;
                        if (is_wave_q) begin
                            wave_wr_en_q <= 1'b1;
                            wave_addr_q  <= wave_addr_d;
                            wave_wdata_q <= {data_hi_q, rx_byte};
                            idx_q        <= idx_q + 8'd1;
                            state_q      <= (idx_q == len_q - 8'd1) ? S_CHK : S_D_HI;
                        end else begin
                            reg_data_q <= {data_hi_q, rx_byte};
                            state_q    <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (rx_byte == chk_q) begin
                            frame_ok_q <= 1'b1;
                            if (!is_wave_q) begin
                                reg_wr_en_q <= 1'b1;
                                reg_addr_q  <= addr_q[7:0];
                                reg_wdata_q <= reg_data_q;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd3;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE) begin
                if (timer_q >= TIMER_LAST) begin
                    timer_q     <= '0;
                    frame_err_q <= 1'b1;
                    err_code_q  <= 2'd0;
                    state_q     <= S_IDLE;
                end else begin
                    timer_q <= timer_q + 32'd1;
                end
            end
        end
    end

    assign bus.reg_wr_en  = reg_wr_en_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_wdata  = reg_wdata_q;
    assign bus.wave_wr_en = wave_wr_en_q;
    assign bus.wave_addr  = wave_addr_q;
    assign bus.wave_wdata = wave_wdata_q;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_code   = err_code_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_decoder
//  Purpose  : Directed frames against uart_cmd_decoder with hand-computed results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_decoder_if #(.WAVE_ADDR_W(AW)) bus ();

    uart_cmd_decoder #(
        .WAVE_ADDR_W    (AW),
        .TIMEOUT_CYCLES (32'd50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Strobe monitor: counters only grow, so tests compare against snapshots.
    int              n_reg = 0, n_wave = 0, n_ok = 0, n_err = 0, n_ok_reg = 0;
    logic [7:0]      last_reg_addr = '0;
    logic [15:0]     last_reg_wdata = '0;
    logic [AW-1:0]   wave_a[$];
    logic [15:0]     wave_d[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.reg_wr_en) begin
                n_reg++;
                last_reg_addr  = bus.reg_addr;
                last_reg_wdata = bus.reg_wdata;
            end
            if (bus.wave_wr_en) begin
                n_wave++;
                wave_a.push_back(bus.wave_addr);
                wave_d.push_back(bus.wave_wdata);
            end
            if (bus.frame_ok)  n_ok++;
            if (bus.frame_err) n_err++;
            if (bus.frame_ok && bus.reg_wr_en) n_ok_reg++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] fb[$];
    int r0, o0, e0, w0, or0;

    task automatic snap();
        r0 = n_reg; o0 = n_ok; e0 = n_err; w0 = n_wave; or0 = n_ok_reg;
    endtask

    task automatic send_frame();
        for (int i = 0; i < fb.size(); i++) begin
            @(negedge clk);
            bus.rx_data  = fb[i];
            bus.rx_valid = 1'b1;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_reg_ok(input string tag);
        snap();
        fb = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h02, 8'h12, 8'h34, 8'h35};
        send_frame();
        check({tag, "_reg_cnt"},   n_reg - r0, 1);
        check({tag, "_reg_addr"},  last_reg_addr, 8'h10);
        check({tag, "_reg_wdata"}, last_reg_wdata, 16'h1234);
        check({tag, "_ok_with_reg"}, n_ok_reg - or0, 1);
        check({tag, "_ok_cnt"},    n_ok - o0, 1);
        check({tag, "_busy"},      bus.busy, 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_reg_wr_en",  bus.reg_wr_en, 0);
        check("rst_wave_wr_en", bus.wave_wr_en, 0);
        check("rst_frame_ok",   bus.frame_ok, 0);
        check("rst_frame_err",  bus.frame_err, 0);
        check("rst_err_code",   bus.err_code, 0);
        check("rst_busy",       bus.busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_reg_ok("t1");

        // Wave write starting at the last RAM word wraps to address 0.
        snap();
        fb = '{8'hA5, 8'h02, 8'h03, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFC};
        send_frame();
        check("t2_wave_cnt", n_wave - w0, 2);
        if (wave_a.size() >= w0 + 2) begin
            check("t2_addr0", wave_a[w0],     10'h3FF);
            check("t2_data0", wave_d[w0],     16'hAABB);
            check("t2_addr1", wave_a[w0 + 1], 10'h000);
            check("t2_data1", wave_d[w0 + 1], 16'hCCDD);
        end
        check("t2_ok_cnt",  n_ok - o0, 1);
        check("t2_reg_cnt", n_reg - r0, 0);

        snap();
        fb = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h02, 8'h12, 8'h34, 8'h36};
        send_frame();
        check("t3_reg_cnt",  n_reg - r0, 0);
        check("t3_err_cnt",  n_err - e0, 1);
        check("t3_ok_cnt",   n_ok - o0, 0);
        check("t3_err_code", bus.err_code, 3);
        check("t3_busy",     bus.busy, 0);

        snap();
        fb = '{8'hA5, 8'h07};
        send_frame();
        check("t4a_err_cnt",  n_err - e0, 1);
        check("t4a_err_code", bus.err_code, 1);
        snap();
        fb = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h03};
        send_frame();
        check("t4b_err_cnt",  n_err - e0, 1);
        check("t4b_err_code", bus.err_code, 2);
        snap();
        fb = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00};
        send_frame();
        check("t4c_err_cnt",  n_err - e0, 1);
        check("t4c_err_code", bus.err_code, 2);
        check("t4c_wave_cnt", n_wave - w0, 0);

        // Reset mid-frame: silent discard, every output cleared.
        snap();
        fb = '{8'hA5, 8'h01, 8'h00, 8'h10};
        send_frame();
        check("t6_busy_pre", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy",     bus.busy, 0);
        check("t6_rst_err_code", bus.err_code, 0);
        check("t6_rst_frame_err", bus.frame_err, 0);
        check("t6_rst_reg_addr", bus.reg_addr, 0);
        check("t6_rst_reg_wdata", bus.reg_wdata, 0);
        check("t6_rst_wave_addr", bus.wave_addr, 0);
        check("t6_rst_wave_wdata", bus.wave_wdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_err_cnt", n_err - e0, 0);
        run_reg_ok("t6");

        snap();
        fb = '{8'hA5, 8'h01};
        send_frame();
        repeat (37) @(negedge clk);
        check("t5_no_early_err", n_err - e0, 0);
        check("t5_busy_wait",    bus.busy, 1);
        for (int c = 0; c < 100 && n_err == e0; c++) @(negedge clk);
        check("t5_err_cnt",  n_err - e0, 1);
        check("t5_err_code", bus.err_code, 0);
        check("t5_busy",     bus.busy, 0);
        run_reg_ok("t5");

        snap();
        fb = '{8'h00, 8'hFF};
        send_frame();
        check("t6n_ok",   n_ok - o0, 0);
        check("t6n_err",  n_err - e0, 0);
        check("t6n_reg",  n_reg - r0, 0);
        check("t6n_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
